instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the main decoder: owns the PC, reads instruction memory over a req/ack handshake,
//  and presents Instr (Instr[31:26] drives the decoder OP) with InstrValid.

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_next_pc_calc.sv | 30 +++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit:
// opcodes, fetch FSM encodings and the default reset PC.
package instr_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for the fetch stage:
// jump, taken branch, or sequential.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit_next_pc_calc (
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] boff;

    assign pc_plus4 = pc + 32'd4;
    assign boff = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

    // Jump outranks a simultaneous taken branch.
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jump:          next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
            branch & zero: next_pc = pc_plus4 + boff;
            default:       next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack handshake, held instruction.
// Optional ack watchdog enabled by defining IMEM_TIMEOUT_EN.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Advance,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        ImemTimeout
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] next_pc;
    logic        take_ack;
    logic        retire;

    assign take_ack = (state == FETCH) && ImemAck;
    assign retire   = (state == HOLD) && Advance;

    instr_fetch_unit_next_pc_calc u_npc (
        .pc        (pc_q),
        .instr_idx (instr_q[25:0]),
        .jump      (Jump),
        .branch    (Branch),
        .zero      (Zero),
        .pc_plus4  (PCPlus4),
        .next_pc   (next_pc)
    );

`ifdef IMEM_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WCNT_W = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [WCNT_W-1:0] TO_LAST =
        WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [WCNT_W-1:0] wcnt;
    logic              wd_hit;

    assign wd_hit = !ImemAck && (wcnt == TO_LAST);

    // Counter idles at zero outside FETCH, so entry clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt <= '0;
        end else if (state != FETCH) begin
            wcnt <= '0;
        end else if (!ImemAck) begin
            wcnt <= wcnt + WCNT_W'(1);
        end
    end

    assign ImemTimeout = (state == FAULT);
`else
    localparam logic TO_TIE = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;

    logic wd_hit;

    assign wd_hit      = 1'b0;
    assign ImemTimeout = TO_TIE;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:  state_nx = FETCH;
            FETCH: begin
                if (ImemAck) begin
                    state_nx = HOLD;
                end else if (wd_hit) begin
                    state_nx = FAULT;
                end
            end
            HOLD:  begin
                if (Advance) begin
                    state_nx = FETCH;
                end
            end
            FAULT: state_nx = FAULT;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= word_align(RESET_PC);
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else if (take_ack) begin
            instr_q <= ImemRData;
            valid_q <= 1'b1;
        end else if (retire) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
        end
    end

    assign ImemReq    = (state == FETCH);
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequencing, wait states,
// branch/jump/wrap, async reset and the optional watchdog.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemRData = 32'h0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Advance = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        ImemTimeout;

    int total = 0;
    int bad = 0;

    instr_fetch_unit #(
        .RESET_PC       (32'h0040_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemRData   (ImemRData),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .Advance     (Advance),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .ImemTimeout (ImemTimeout)
    );

    always #5 CLK = ~CLK;

    // Stimulus helpers (no checking): leave state FETCH / HOLD.
    task automatic do_reset();
        RST = 1'b1;
        ImemAck = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic fetch(input logic [31:0] d);
        ImemAck = 1'b1;
        ImemRData = d;
        @(negedge CLK);
        ImemAck = 1'b0;
    endtask

    task automatic retire(input logic j, input logic b, input logic z);
        Advance = 1'b1;
        Jump = j;
        Branch = b;
        Zero = z;
        @(negedge CLK);
        Advance = 1'b0;
        Jump = 1'b0;
        Branch = 1'b0;
        Zero = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++;
        if ({ImemReq, InstrValid, ImemTimeout} !== 3'b000) begin
            bad++;
            $display("FAIL rst_ctl got=%b exp=000",
                     {ImemReq, InstrValid, ImemTimeout});
        end
        total++;
        if (PC !== 32'h0040_0000 || Instr !== 32'h0) begin
            bad++;
            $display("FAIL rst_regs pc=%h instr=%h exp pc=00400000 instr=0",
                     PC, Instr);
        end
        RST = 1'b0;
        ImemAck = 1'b1;
        ImemRData = 32'h0;
        #1;
        total++;
        if (ImemReq !== 1'b0) begin
            bad++;
            $display("FAIL boot_req got=%b exp=0", ImemReq);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            exp = 32'h0040_0000 + 32'(4 * i);
            total++;
            if (ImemReq !== 1'b1 || ImemAddr !== exp) begin
                bad++;
                $display("FAIL seq_addr%0d req=%b addr=%h exp 1/%h",
                         i, ImemReq, ImemAddr, exp);
            end
            @(negedge CLK);
            total++;
            if (InstrValid !== 1'b1 || PC !== exp) begin
                bad++;
                $display("FAIL seq_hold%0d v=%b pc=%h exp 1/%h",
                         i, InstrValid, PC, exp);
            end
            Advance = 1'b1;
            @(negedge CLK);
            Advance = 1'b0;
        end
        ImemAck = 1'b0;
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ImemReq !== 1'b1 || ImemAddr !== 32'h0040_000C ||
                InstrValid !== 1'b0) begin
                bad++;
                $display("FAIL wait%0d req=%b addr=%h v=%b exp 1/0040000c/0",
                         k, ImemReq, ImemAddr, InstrValid);
            end
            if (k == 2) begin
                ImemAck = 1'b1;
                ImemRData = 32'h1234_5678;
            end
            @(negedge CLK);
        end
        ImemAck = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || Instr !== 32'h1234_5678 ||
            ImemReq !== 1'b0) begin
            bad++;
            $display("FAIL wait_data v=%b instr=%h req=%b exp 1/12345678/0",
                     InstrValid, Instr, ImemReq);
        end
        ImemAck = 1'b1;
        ImemRData = 32'hDEAD_BEEF;
        @(negedge CLK);
        ImemAck = 1'b0;
        total++;
        if (Instr !== 32'h1234_5678 || InstrValid !== 1'b1 ||
            PC !== 32'h0040_000C) begin
            bad++;
            $display("FAIL hold_ack instr=%h v=%b pc=%h exp 12345678/1/0040000c",
                     Instr, InstrValid, PC);
        end
    endtask

    task automatic test_branch();
        do_reset();
        fetch(32'h1000_0003);
        total++;
        if (PC !== 32'h0040_0000 || Instr !== 32'h1000_0003 ||
            PCPlus4 !== 32'h0040_0004) begin
            bad++;
            $display("FAIL br_hold pc=%h instr=%h p4=%h", PC, Instr, PCPlus4);
        end
        retire(1'b0, 1'b1, 1'b1);
        total++;
        if (PC !== 32'h0040_0010 || InstrValid !== 1'b0 ||
            ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL br_taken pc=%h v=%b req=%b exp 00400010/0/1",
                     PC, InstrValid, ImemReq);
        end
        do_reset();
        fetch(32'h1000_0003);
        retire(1'b0, 1'b1, 1'b0);
        total++;
        if (PC !== 32'h0040_0004) begin
            bad++;
            $display("FAIL br_not_taken got=%h exp=00400004", PC);
        end
    endtask

    task automatic test_jump();
        do_reset();
        fetch(32'h0);
        retire(1'b0, 1'b0, 1'b0);
        fetch(32'h0);
        retire(1'b0, 1'b0, 1'b0);
        total++;
        if (PC !== 32'h0040_0008) begin
            bad++;
            $display("FAIL jmp_pre got=%h exp=00400008", PC);
        end
        fetch(32'h0810_0000);
        retire(1'b1, 1'b1, 1'b1);
        total++;
        if (PC !== 32'h0040_0000) begin
            bad++;
            $display("FAIL jmp_prio got=%h exp=00400000", PC);
        end
    endtask

    task automatic test_wrap();
        fetch(32'h0800_0000);
        retire(1'b1, 1'b0, 1'b0);
        total++;
        if (PC !== 32'h0) begin
            bad++;
            $display("FAIL jmp_zero got=%h exp=00000000", PC);
        end
        fetch(32'h1000_FFFE);
        retire(1'b0, 1'b1, 1'b1);
        total++;
        if (PC !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL br_back got=%h exp=fffffffc", PC);
        end
        fetch(32'h0);
        total++;
        if (PCPlus4 !== 32'h0) begin
            bad++;
            $display("FAIL p4_wrap got=%h exp=00000000", PCPlus4);
        end
        retire(1'b0, 1'b0, 1'b0);
        total++;
        if (PC !== 32'h0 || ImemAddr !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap pc=%h addr=%h exp 0", PC, ImemAddr);
        end
    endtask

    task automatic test_async_reset();
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (ImemReq !== 1'b0 || PC !== 32'h0040_0000 ||
            InstrValid !== 1'b0) begin
            bad++;
            $display("FAIL async_rst req=%b pc=%h v=%b exp 0/00400000/0",
                     ImemReq, PC, InstrValid);
        end
        ImemAck = 1'b1;
        ImemRData = 32'h0BAD_0BAD;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        ImemAck = 1'b0;
        total++;
        if (InstrValid !== 1'b0 || Instr !== 32'h0 || ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL late_ack v=%b instr=%h req=%b exp 0/0/1",
                     InstrValid, Instr, ImemReq);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ImemReq !== 1'b1 || ImemTimeout !== 1'b0) begin
                bad++;
                $display("FAIL to_wait%0d req=%b to=%b exp 1/0",
                         i, ImemReq, ImemTimeout);
            end
            @(negedge CLK);
        end
`ifdef IMEM_TIMEOUT_EN
        total++;
        if (ImemTimeout !== 1'b1 || ImemReq !== 1'b0 ||
            InstrValid !== 1'b0) begin
            bad++;
            $display("FAIL to_fault to=%b req=%b v=%b exp 1/0/0",
                     ImemTimeout, ImemReq, InstrValid);
        end
        ImemAck = 1'b1;
        Advance = 1'b1;
        repeat (3) @(negedge CLK);
        ImemAck = 1'b0;
        Advance = 1'b0;
        total++;
        if (ImemTimeout !== 1'b1 || ImemReq !== 1'b0) begin
            bad++;
            $display("FAIL to_sticky to=%b req=%b exp 1/0",
                     ImemTimeout, ImemReq);
        end
        do_reset();
        total++;
        if (ImemTimeout !== 1'b0 || ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL to_clear to=%b req=%b exp 0/1",
                     ImemTimeout, ImemReq);
        end
`else
        repeat (20) @(negedge CLK);
        total++;
        if (ImemReq !== 1'b1 || ImemTimeout !== 1'b0) begin
            bad++;
            $display("FAIL no_wd req=%b to=%b exp 1/0",
                     ImemReq, ImemTimeout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jump();
        test_wrap();
        test_async_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
